// File: rtl/alu_arbiter.sv
// ---------------------------------------------------------------------------
// alu_arbiter
//   Two requesters share one ALU with a single registered result slot.
//   A requester is granted when the slot is free: it is empty, or it is
//   being consumed in the same cycle. The ALU result is captured on the
//   grant edge and presented one cycle later until the consumer takes it.
//
//   Optional feature macro: ALU_ARB_ROUND_ROBIN_EN
//     defined   : on a tie the requester that was not last granted wins
//     undefined : requester 0 always wins a tie; no pointer register exists
//
// Ports
//   clk                     single clock, rising edge
//   rst                     synchronous, active-high reset
//   req0_valid / req1_valid requester has an operation
//   req0_ready / req1_ready operation accepted this cycle (combinational)
//   req0_op / req1_op       opcode: 0 AND, 1 OR, 2 XOR, 3 ADD, 4 SUB,
//                           5 SLT (signed), 6 SLL, 7 SRL
//   req0_a/b, req1_a/b      WIDTH-bit operands
//   rsp_valid               result slot holds a result
//   rsp_ready               consumer takes the result this cycle
//   rsp_id                  requester that produced the held result
//   rsp_data                held result
//   rsp_zero                rsp_data == 0
//
// FSM states
//   state | meaning
//   ------+-----------------------------------------------
//   EMPTY | no result held, rsp_valid = 0
//   FULL  | result held and presented, rsp_valid = 1
// ---------------------------------------------------------------------------
module alu_arbiter #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req0_valid,
   output logic             req0_ready,
   input  logic [2:0]       req0_op,
   input  logic [WIDTH-1:0] req0_a,
   input  logic [WIDTH-1:0] req0_b,
   input  logic             req1_valid,
   output logic             req1_ready,
   input  logic [2:0]       req1_op,
   input  logic [WIDTH-1:0] req1_a,
   input  logic [WIDTH-1:0] req1_b,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic             rsp_id,
   output logic [WIDTH-1:0] rsp_data,
   output logic             rsp_zero
);

   localparam int SHW = $clog2(WIDTH);

   localparam logic [2:0] OP_AND = 3'd0;
   localparam logic [2:0] OP_OR  = 3'd1;
   localparam logic [2:0] OP_XOR = 3'd2;
   localparam logic [2:0] OP_ADD = 3'd3;
   localparam logic [2:0] OP_SUB = 3'd4;
   localparam logic [2:0] OP_SLT = 3'd5;
   localparam logic [2:0] OP_SLL = 3'd6;
   localparam logic [2:0] OP_SRL = 3'd7;

   typedef enum logic {
      EMPTY = 1'b0,
      FULL  = 1'b1
   } state_t;

   state_t           state;
   state_t           state_nxt;

   logic             slot_free;
   logic             grant_ok;
   logic             grant;
   logic             sel;
   logic             tie_to1;

   logic [2:0]       op;
   logic [WIDTH-1:0] opa;
   logic [WIDTH-1:0] opb;
   logic [SHW-1:0]   shamt;
   logic             lt;
   logic [WIDTH-1:0] alu_result;

   // ------------------------------------------------------------------------
   // Tie-break selection
   // ------------------------------------------------------------------------
`ifdef ALU_ARB_ROUND_ROBIN_EN
   logic last_grant;

   // Requester 1 wins a tie only when requester 0 was granted last.
   assign tie_to1 = ~last_grant;

   always_ff @(posedge clk) begin
      if (rst) begin
         last_grant <= 1'b1;
      end else if (grant) begin
         last_grant <= sel;
      end
   end
`else
   assign tie_to1 = 1'b0;
`endif

   // ------------------------------------------------------------------------
   // Grant logic
   // ------------------------------------------------------------------------
   // The slot can be refilled in the same cycle it is drained, which gives
   // back-to-back results with no bubble.
   assign slot_free = (state == EMPTY) || rsp_ready;
   assign grant_ok  = !rst && slot_free;

   always_comb begin
      req0_ready = 1'b0;
      req1_ready = 1'b0;
      if (grant_ok) begin
         if (req0_valid && req1_valid) begin
            req0_ready = ~tie_to1;
            req1_ready = tie_to1;
         end else begin
            req0_ready = req0_valid;
            req1_ready = req1_valid;
         end
      end
   end

   assign grant = req0_ready | req1_ready;
   assign sel   = req1_ready;

   // ------------------------------------------------------------------------
   // ALU on the selected requester's operands
   // ------------------------------------------------------------------------
   assign op    = sel ? req1_op : req0_op;
   assign opa   = sel ? req1_a  : req0_a;
   assign opb   = sel ? req1_b  : req0_b;
   assign shamt = opb[SHW-1:0];
   assign lt    = $signed(opa) < $signed(opb);

   always_comb begin
      alu_result = '0;
      case (op)
         OP_AND:  alu_result = opa & opb;
         OP_OR:   alu_result = opa | opb;
         OP_XOR:  alu_result = opa ^ opb;
         OP_ADD:  alu_result = opa + opb;
         OP_SUB:  alu_result = opa - opb;
         OP_SLT:  alu_result = {{(WIDTH-1){1'b0}}, lt};
         OP_SLL:  alu_result = opa << shamt;
         OP_SRL:  alu_result = opa >> shamt;
         default: alu_result = '0;
      endcase
   end

   // ------------------------------------------------------------------------
   // Slot FSM
   // ------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= EMPTY;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         EMPTY: begin
            if (grant) begin
               state_nxt = FULL;
            end
         end
         FULL: begin
            if (rsp_ready && !grant) begin
               state_nxt = EMPTY;
            end
         end
         default: state_nxt = EMPTY;
      endcase
   end

   assign rsp_valid = (state == FULL);

   // ------------------------------------------------------------------------
   // Result registers: loaded only on a grant, so they hold while stalled.
   // ------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         rsp_data <= '0;
         rsp_id   <= 1'b0;
         rsp_zero <= 1'b0;
      end else if (grant) begin
         rsp_data <= alu_result;
         rsp_id   <= sel;
         rsp_zero <= (alu_result == '0);
      end
   end

endmodule

// File: tb/tb_alu_arbiter.sv
// ---------------------------------------------------------------------------
// tb_alu_arbiter
//   Self-checking bench for alu_arbiter (WIDTH = 32): a table of single
//   operations, hand-written multi-cycle sequences, and a randomized run
//   against a behavioural model. Works with ALU_ARB_ROUND_ROBIN_EN either
//   defined or undefined.
// ---------------------------------------------------------------------------
module tb_alu_arbiter;

`ifdef ALU_ARB_ROUND_ROBIN_EN
   localparam bit RR = 1'b1;
`else
   localparam bit RR = 1'b0;
`endif

   logic        clk;
   logic        rst;
   logic        req0_valid, req0_ready;
   logic [2:0]  req0_op;
   logic [31:0] req0_a, req0_b;
   logic        req1_valid, req1_ready;
   logic [2:0]  req1_op;
   logic [31:0] req1_a, req1_b;
   logic        rsp_valid, rsp_ready, rsp_id, rsp_zero;
   logic [31:0] rsp_data;

   int n_cmp = 0;
   int n_err = 0;

   alu_arbiter #(.WIDTH(32)) dut (
      .clk        (clk),
      .rst        (rst),
      .req0_valid (req0_valid),
      .req0_ready (req0_ready),
      .req0_op    (req0_op),
      .req0_a     (req0_a),
      .req0_b     (req0_b),
      .req1_valid (req1_valid),
      .req1_ready (req1_ready),
      .req1_op    (req1_op),
      .req1_a     (req1_a),
      .req1_b     (req1_b),
      .rsp_valid  (rsp_valid),
      .rsp_ready  (rsp_ready),
      .rsp_id     (rsp_id),
      .rsp_data   (rsp_data),
      .rsp_zero   (rsp_zero)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      @(negedge clk);
   endtask

   task automatic idle_inputs();
      req0_valid = 0; req0_op = 0; req0_a = 0; req0_b = 0;
      req1_valid = 0; req1_op = 0; req1_a = 0; req1_b = 0;
      rsp_ready  = 0;
   endtask

   task automatic do_reset();
      rst = 1;
      tick();
      rst = 0;
   endtask

   // Reference ALU written from the opcode definitions.
   function automatic logic [31:0] ref_alu(input int op, input logic [31:0] a, input logic [31:0] b);
      case (op)
         0: return a & b;
         1: return a | b;
         2: return a ^ b;
         3: return a + b;
         4: return a - b;
         5: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         6: return a << (b % 32);
         default: return a >> (b % 32);
      endcase
   endfunction

   typedef struct {
      logic        id;
      logic [2:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] exp;
      logic        z;
   } vec_t;

   vec_t vt[12];

   task automatic apply_vec(input vec_t v);
      idle_inputs();
      rsp_ready = 1;
      if (v.id) begin
         req1_valid = 1; req1_op = v.op; req1_a = v.a; req1_b = v.b;
      end else begin
         req0_valid = 1; req0_op = v.op; req0_a = v.a; req0_b = v.b;
      end
      settle();
      chk("vec_ready0", {31'd0, req0_ready}, {31'd0, ~v.id});
      chk("vec_ready1", {31'd0, req1_ready}, {31'd0, v.id});
      tick();
      req0_valid = 0;
      req1_valid = 0;
      settle();
      chk("vec_rsp_valid", {31'd0, rsp_valid}, 32'd1);
      chk("vec_rsp_data", rsp_data, v.exp);
      chk("vec_rsp_id", {31'd0, rsp_id}, {31'd0, v.id});
      chk("vec_rsp_zero", {31'd0, rsp_zero}, {31'd0, v.z});
      tick();
   endtask

   // Behavioural model state for the random run
   logic        m_valid;
   logic [31:0] m_data;
   logic        m_id;
   logic        m_zero;
   int          m_last;

   initial begin
      int g, prev_g, w;
      logic free;
      logic [31:0] res;

      vt[0]  = '{1'b0, 3'd1, 32'h0000FFFF, 32'hFFFF0000, 32'hFFFFFFFF, 1'b0};
      vt[1]  = '{1'b1, 3'd4, 32'd3,        32'd3,        32'd0,        1'b1};
      vt[2]  = '{1'b1, 3'd5, 32'hFFFFFFFF, 32'd1,        32'd1,        1'b0};
      vt[3]  = '{1'b0, 3'd6, 32'd1,        32'h00000021, 32'd2,        1'b0};
      vt[4]  = '{1'b0, 3'd3, 32'd1,        32'd2,        32'd3,        1'b0};
      vt[5]  = '{1'b0, 3'd0, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 1'b0};
      vt[6]  = '{1'b1, 3'd2, 32'hAAAAAAAA, 32'hFFFFFFFF, 32'h55555555, 1'b0};
      vt[7]  = '{1'b0, 3'd7, 32'h80000000, 32'h0000001F, 32'd1,        1'b0};
      vt[8]  = '{1'b0, 3'd3, 32'hFFFFFFFF, 32'd1,        32'd0,        1'b1};
      vt[9]  = '{1'b1, 3'd4, 32'd0,        32'd1,        32'hFFFFFFFF, 1'b0};
      vt[10] = '{1'b0, 3'd5, 32'd1,        32'hFFFFFFFF, 32'd0,        1'b1};
      vt[11] = '{1'b1, 3'd7, 32'h80000000, 32'h00000024, 32'h08000000, 1'b0};

      // ---------------- reset behaviour ----------------
      idle_inputs();
      rst = 1;
      req0_valid = 1;
      req1_valid = 1;
      rsp_ready  = 1;
      settle();
      chk("rst_ready0", {31'd0, req0_ready}, 32'd0);
      chk("rst_ready1", {31'd0, req1_ready}, 32'd0);
      tick();
      settle();
      chk("rst_ready0_b", {31'd0, req0_ready}, 32'd0);
      chk("rst_rsp_valid_during", {31'd0, rsp_valid}, 32'd0);
      tick();
      rst = 0;
      idle_inputs();
      settle();
      chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      chk("rst_rsp_data", rsp_data, 32'd0);
      chk("rst_rsp_id", {31'd0, rsp_id}, 32'd0);
      chk("rst_rsp_zero", {31'd0, rsp_zero}, 32'd0);
      tick();

      // ---------------- table of single operations ----------------
      for (int i = 0; i < 12; i++) apply_vec(vt[i]);
      idle_inputs();
      tick();

      // ---------------- both requesters valid continuously ----------------
      do_reset();
      idle_inputs();
      req0_valid = 1; req0_op = 3'd3; req0_a = 32'd10; req0_b = 32'd0;
      req1_valid = 1; req1_op = 3'd3; req1_a = 32'd20; req1_b = 32'd0;
      rsp_ready  = 1;
      prev_g = -1;
      for (int k = 0; k < 6; k++) begin
         g = RR ? (k % 2) : 0;
         settle();
         chk("tie_ready0", {31'd0, req0_ready}, (g == 0) ? 32'd1 : 32'd0);
         chk("tie_ready1", {31'd0, req1_ready}, (g == 1) ? 32'd1 : 32'd0);
         if (k > 0) begin
            chk("tie_rsp_valid", {31'd0, rsp_valid}, 32'd1);
            chk("tie_rsp_id", {31'd0, rsp_id}, prev_g[31:0]);
            chk("tie_rsp_data", rsp_data, (prev_g == 0) ? 32'd10 : 32'd20);
         end
         prev_g = g;
         tick();
      end

      // ---------------- stall with result held, then no-bubble refill ----------------
      do_reset();
      idle_inputs();
      req1_valid = 1; req1_op = 3'd2; req1_a = 32'hAAAAAAAA; req1_b = 32'hFFFFFFFF;
      settle();
      chk("hold_first_grant", {31'd0, req1_ready}, 32'd1);
      tick();
      req0_valid = 1; req0_op = 3'd3; req0_a = 32'd1; req0_b = 32'd2;
      for (int k = 0; k < 5; k++) begin
         settle();
         chk("hold_rsp_valid", {31'd0, rsp_valid}, 32'd1);
         chk("hold_rsp_data", rsp_data, 32'h55555555);
         chk("hold_rsp_id", {31'd0, rsp_id}, 32'd1);
         chk("hold_ready0", {31'd0, req0_ready}, 32'd0);
         chk("hold_ready1", {31'd0, req1_ready}, 32'd0);
         tick();
      end
      req1_valid = 0;
      rsp_ready  = 1;
      settle();
      chk("refill_ready0", {31'd0, req0_ready}, 32'd1);
      tick();
      req0_valid = 0;
      rsp_ready  = 0;
      settle();
      chk("refill_rsp_valid", {31'd0, rsp_valid}, 32'd1);
      chk("refill_rsp_data", rsp_data, 32'd3);
      chk("refill_rsp_id", {31'd0, rsp_id}, 32'd0);

      // ---------------- reset while FULL with req1 waiting ----------------
      req1_valid = 1; req1_op = 3'd3; req1_a = 32'd7; req1_b = 32'd0;
      rst = 1;
      settle();
      chk("rstfull_ready1", {31'd0, req1_ready}, 32'd0);
      tick();
      rst = 0;
      req0_valid = 1; req0_op = 3'd3; req0_a = 32'd5; req0_b = 32'd0;
      rsp_ready  = 1;
      settle();
      chk("rstfull_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      chk("rstfull_tie_ready0", {31'd0, req0_ready}, 32'd1);
      chk("rstfull_tie_ready1", {31'd0, req1_ready}, 32'd0);
      tick();
      idle_inputs();
      settle();
      chk("rstfull_rsp_id", {31'd0, rsp_id}, 32'd0);
      chk("rstfull_rsp_data", rsp_data, 32'd5);
      tick();

      // ---------------- randomized run against the model ----------------
      do_reset();
      m_valid = 0; m_data = 0; m_id = 0; m_zero = 0; m_last = 1;
      for (int c = 0; c < 1500; c++) begin
         rst        = ($urandom_range(0, 49) == 0);
         req0_valid = ($urandom_range(0, 3) != 0);
         req1_valid = ($urandom_range(0, 3) != 0);
         req0_op    = 3'($urandom_range(0, 7));
         req1_op    = 3'($urandom_range(0, 7));
         req0_a     = $urandom;
         req1_a     = $urandom;
         req0_b     = ($urandom_range(0, 3) == 0) ? req0_a : $urandom;
         req1_b     = ($urandom_range(0, 3) == 0) ? req1_a : 32'($urandom_range(0, 40));
         rsp_ready  = ($urandom_range(0, 2) != 0);
         settle();

         chk("rnd_rsp_valid", {31'd0, rsp_valid}, {31'd0, m_valid});
         if (m_valid) begin
            chk("rnd_rsp_data", rsp_data, m_data);
            chk("rnd_rsp_id", {31'd0, rsp_id}, {31'd0, m_id});
            chk("rnd_rsp_zero", {31'd0, rsp_zero}, {31'd0, m_zero});
         end

         free = !m_valid || rsp_ready;
         w = -1;
         if (!rst && free) begin
            if (req0_valid && req1_valid) w = RR ? ((m_last == 1) ? 0 : 1) : 0;
            else if (req0_valid)          w = 0;
            else if (req1_valid)          w = 1;
         end
         chk("rnd_ready0", {31'd0, req0_ready}, (w == 0) ? 32'd1 : 32'd0);
         chk("rnd_ready1", {31'd0, req1_ready}, (w == 1) ? 32'd1 : 32'd0);

         if (rst) begin
            m_valid = 0; m_data = 0; m_id = 0; m_zero = 0; m_last = 1;
         end else if (w >= 0) begin
            res     = (w == 0) ? ref_alu(int'(req0_op), req0_a, req0_b)
                               : ref_alu(int'(req1_op), req1_a, req1_b);
            m_valid = 1;
            m_data  = res;
            m_id    = (w == 1);
            m_zero  = (res == 0);
            m_last  = w;
         end else if (m_valid && rsp_ready) begin
            m_valid = 0;
         end
         tick();
      end

      idle_inputs();
      rst = 0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
